// File: rtl/mag_compare_seq.sv
// mag_compare_seq: sequential unsigned magnitude comparator.
//
// One 2-bit compare slice is reused across WIDTH/2 clock cycles, scanning the
// operands most-significant digit first. The first differing digit decides the
// result and freezes the decided flags. Results are registered and published
// on the edge that enters DONE, together with a one-cycle done pulse.
//
// Optional feature macro: MAG_CMP_EARLY_EXIT_EN
//   defined   : RUN ends in the cycle that first decides the result.
//   undefined : RUN always scans all digits (fixed latency WIDTH/2 + 1).
//
// Ports:
//   i_clk     : clock, all state changes on the rising edge
//   i_reset_n : synchronous active-low reset
//   i_start   : request a compare, accepted only while o_ready = 1
//   i_a, i_b  : operands, sampled on the accepted start edge
//   o_ready   : high in IDLE (combinational from state)
//   o_done    : one-cycle pulse when o_agtb / o_aeqb update
//   o_agtb    : registered A > B (unsigned)
//   o_aeqb    : registered A == B
module mag_compare_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_agtb,
    output logic             o_aeqb
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [CntW-1:0]    r_cnt;
    logic               r_gt_f;
    logic               r_lt_f;
    logic               r_done;
    logic               r_agtb;
    logic               r_aeqb;

    state_e             w_state_nxt;
    logic [WIDTH-1:0]   w_sa_nxt;
    logic [WIDTH-1:0]   w_sb_nxt;
    logic [CntW-1:0]    w_cnt_nxt;
    logic               w_gt_f_nxt;
    logic               w_lt_f_nxt;
    logic               w_done_nxt;
    logic               w_agtb_nxt;
    logic               w_aeqb_nxt;

    logic [1:0]         w_da;
    logic [1:0]         w_db;
    logic               w_slice_gt;
    logic               w_slice_lt;
    logic               w_gt_fin;
    logic               w_lt_fin;
    logic               w_exit;

    assign w_da       = r_sa[WIDTH-1 -: 2];
    assign w_db       = r_sb[WIDTH-1 -: 2];
    assign w_slice_gt = (w_da > w_db);
    assign w_slice_lt = (w_da < w_db);

    // Flags including the digit processed this cycle; a decided compare is frozen.
    assign w_gt_fin = (r_gt_f | r_lt_f) ? r_gt_f : w_slice_gt;
    assign w_lt_fin = (r_gt_f | r_lt_f) ? r_lt_f : w_slice_lt;

`ifdef MAG_CMP_EARLY_EXIT_EN
    assign w_exit = (r_cnt == '0) | w_gt_fin | w_lt_fin;
`else
    assign w_exit = (r_cnt == '0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sa_nxt    = r_sa;
        w_sb_nxt    = r_sb;
        w_cnt_nxt   = r_cnt;
        w_gt_f_nxt  = r_gt_f;
        w_lt_f_nxt  = r_lt_f;
        w_done_nxt  = 1'b0;
        w_agtb_nxt  = r_agtb;
        w_aeqb_nxt  = r_aeqb;

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_sa_nxt    = i_a;
                    w_sb_nxt    = i_b;
                    w_cnt_nxt   = CntW'(N - 1);
                    w_gt_f_nxt  = 1'b0;
                    w_lt_f_nxt  = 1'b0;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_gt_f_nxt = w_gt_fin;
                w_lt_f_nxt = w_lt_fin;
                w_sa_nxt   = r_sa << 2;
                w_sb_nxt   = r_sb << 2;
                w_cnt_nxt  = r_cnt - CntW'(1);
                if (w_exit) begin
                    w_agtb_nxt  = w_gt_fin;
                    w_aeqb_nxt  = ~(w_gt_fin | w_lt_fin);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_gt_f  <= 1'b0;
            r_lt_f  <= 1'b0;
            r_done  <= 1'b0;
            r_agtb  <= 1'b0;
            r_aeqb  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sa    <= w_sa_nxt;
            r_sb    <= w_sb_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gt_f  <= w_gt_f_nxt;
            r_lt_f  <= w_lt_f_nxt;
            r_done  <= w_done_nxt;
            r_agtb  <= w_agtb_nxt;
            r_aeqb  <= w_aeqb_nxt;
        end
    end

    assign o_ready = (r_state == StIdle);
    assign o_done  = r_done;
    assign o_agtb  = r_agtb;
    assign o_aeqb  = r_aeqb;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Self-checking bench for mag_compare_seq (WIDTH = 8). Expected results come
// from plain integer comparison; expected latency from locating the first
// differing 2-bit digit of the operands.
module tb_mag_compare_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             agtb;
    logic             aeqb;

    int n_checks = 0;
    int n_errors = 0;

    // Last published results expected at the outputs.
    logic m_agtb = 1'b0;
    logic m_aeqb = 1'b0;

    mag_compare_seq #(
        .WIDTH (WIDTH)
    ) u_dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
        .o_ready   (ready),
        .o_done    (done),
        .o_agtb    (agtb),
        .o_aeqb    (aeqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle (relative to the start cycle 0) in which done is expected.
    function automatic int exp_latency(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int unsigned x = av;
        int unsigned y = bv;
        int first = 0;
        int lat = N + 1;
        for (int j = 1; j <= N; j++) begin
            if (first == 0 && ((x >> (WIDTH - 2 * j)) % 4) != ((y >> (WIDTH - 2 * j)) % 4))
                first = j;
        end
`ifdef MAG_CMP_EARLY_EXIT_EN
        if (first != 0) lat = first + 1;
`endif
        return lat;
    endfunction

    // Entered and left on a falling edge; the entry cycle is cycle 0.
    // When inject is set, start is pulsed with other operands in cycles 2 and 3.
    task automatic run_compare(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input bit inject);
        int cyc;
        int lat;
        bit seen;
        lat = exp_latency(av, bv);
        check_val("ready_before_start", {31'b0, ready}, 32'd1);
        start = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        cyc = 1;
        seen = 1'b0;
        start = 1'b0;
        while (cyc <= 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            check_val("ready_in_run", {31'b0, ready}, 32'd0);
            check_val("agtb_hold", {31'b0, agtb}, {31'b0, m_agtb});
            check_val("aeqb_hold", {31'b0, aeqb}, {31'b0, m_aeqb});
            if (inject && (cyc == 2 || cyc == 3)) begin
                start = 1'b1;
                a = ~av;
                b = ~bv;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_val("done_seen", {31'b0, seen}, 32'd1);
        check_val("latency", cyc, lat);
        m_agtb = (av > bv);
        m_aeqb = (av == bv);
        check_val("agtb", {31'b0, agtb}, {31'b0, m_agtb});
        check_val("aeqb", {31'b0, aeqb}, {31'b0, m_aeqb});
        @(negedge clk);
        check_val("done_pulse_end", {31'b0, done}, 32'd0);
        check_val("ready_after_done", {31'b0, ready}, 32'd1);
        check_val("agtb_after", {31'b0, agtb}, {31'b0, m_agtb});
        check_val("aeqb_after", {31'b0, aeqb}, {31'b0, m_aeqb});
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"}, {31'b0, ready}, 32'd1);
        check_val({tag, "_done"},  {31'b0, done},  32'd0);
        check_val({tag, "_agtb"},  {31'b0, agtb},  {31'b0, m_agtb});
        check_val({tag, "_aeqb"},  {31'b0, aeqb},  {31'b0, m_aeqb});
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state held through idle cycles.
        for (int i = 0; i < 10; i++) begin
            check_idle_outputs("idle");
            @(negedge clk);
        end

        // Directed cases.
        run_compare(8'hA5, 8'hA4, 1'b0);
        run_compare(8'h80, 8'h7F, 1'b0);
        run_compare(8'h3C, 8'h3C, 1'b0);
        run_compare(8'h12, 8'h21, 1'b0);   // back-to-back with the previous one
        run_compare(8'h3D, 8'h3C, 1'b1);   // start pulses during RUN must be ignored
        run_compare(8'h00, 8'h00, 1'b0);
        run_compare(8'hFF, 8'hFE, 1'b0);
        run_compare(8'h00, 8'hFF, 1'b0);

        // Reset in the middle of a compare.
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        @(negedge clk);                    // cycle 1
        start = 1'b0;
        @(negedge clk);                    // cycle 2
        reset_n = 1'b0;
        @(negedge clk);                    // cycle 3
        m_agtb = 1'b0;
        m_aeqb = 1'b0;
        check_idle_outputs("rst_mid");
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_idle_outputs("rst_after");
        end

        // Randomized compares with occasional near-equal operands and idle gaps.
        for (int i = 0; i < 60; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            run_compare(ra, rb, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check_idle_outputs("gap");
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mag_compare_seq.md
# mag_compare_seq

Sequential magnitude-compare controller. It sequences a 2-bit compare slice (greater-than plus equality) across two WIDTH-bit operands, most-significant digit first, one 2-bit digit per clock. It sits between operand registers and consumers that need a registered a>b / a==b result with a start/done handshake. Sharing one 2-bit slice across cycles replaces a full-width combinational comparator.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥ 2. N = WIDTH/2 digits.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset_n, input, 1, synchronous active-low reset.
- start, input, 1, request a comparison; accepted only when ready=1.
- a, input, WIDTH, operand A; sampled on the accepted start edge only.
- b, input, WIDTH, operand B; sampled on the accepted start edge only.
- ready, output, 1, high in IDLE.
- done, output, 1, one-cycle pulse when the result registers update.
- agtb, output, 1, registered result: A > B (unsigned).
- aeqb, output, 1, registered result: A == B.

## Operation
- States: IDLE, RUN, DONE. Reset (reset_n=0 at a rising edge) forces IDLE and sets ready=1, done=0, agtb=0, aeqb=0. Shift registers and the digit counter are cleared.
- IDLE, start=1:
  - Load shift registers sa←a and sb←b.
  - Load digit counter cnt←N-1.
  - Clear the decided flags gt_f and lt_f.
  - Go to RUN.
- IDLE, start=0: hold all state.
- RUN, each cycle, using the top digit da=sa[WIDTH-1:WIDTH-2] and db=sb[WIDTH-1:WIDTH-2]:
  - Slice gt = (da > db), unsigned 2-bit; slice lt = (da < db).
  - If gt_f and lt_f are both 0: set gt_f←gt and lt_f←lt. Once either flag is set, it is frozen.
  - Shift sa and sb left by 2 (zero fill) and decrement cnt.
  - Leave RUN when cnt==0 after processing the current digit, or as defined under Configuration.
- Leaving RUN:
  - agtb←(final gt_f). The final flags include the digit processed in this cycle.
  - aeqb←~(final gt_f | final lt_f).
  - Go to DONE.
- DONE: done=1 for exactly this cycle; then IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued.
- agtb and aeqb change only on the edge entering DONE. Otherwise they hold, including through a new RUN.
- agtb and aeqb are never both 1. Both 0 means A < B (after the first done).
- Arithmetic is unsigned; there is no sign handling.
- Reset mid-RUN or mid-DONE aborts the comparison. All outputs return to reset values on that edge, and no done is produced.

## Timing
- Start accepted at the edge ending cycle 0. RUN occupies cycles 1..N. done=1 and results are valid in cycle N+1. ready=1 again in cycle N+2.
- Full-mode latency is start-edge to done = N+1 cycles, independent of the data.
- Back-to-back throughput: a new start can be accepted in cycle N+2, so one comparison per N+2 cycles.
- ready is combinational from state. done, agtb and aeqb are registered.

## Configuration
- MAG_CMP_EARLY_EXIT_EN defined: RUN exits in the cycle that first sets gt_f or lt_f.
  - If the first differing digit is digit j (j=1 is the MSB digit, processed in cycle j), done occurs in cycle j+1.
  - Equal operands still take N RUN cycles.
- Not defined: RUN always runs all N digits. Latency is fixed at N+1.
- Results are identical in both modes; only latency differs.

## Test plan
WIDTH=8 (N=4) for all cases.
- Reset, then idle: ready=1, done=0, agtb=0, aeqb=0 held; start=0 for 10 cycles → no change.
- a=0xA5, b=0xA4, start in cycle 0 → done in cycle 5, agtb=1, aeqb=0, in both modes (difference is in the LSB digit).
- a=0x80, b=0x7F → agtb=1. done in cycle 5 without the macro; in cycle 2 with MAG_CMP_EARLY_EXIT_EN.
- a=0x3C, b=0x3C → aeqb=1, agtb=0, done in cycle 5 (both modes). Then a=0x12, b=0x21 back-to-back at cycle 6 → agtb=0, aeqb=0. Results from the first compare hold until the second done.
- Start pulsed in cycles 2 and 3 during RUN with different operands → ignored; the result reflects the cycle-0 operands and there is exactly one done pulse.
- reset_n=0 at the edge ending cycle 2 of a 0xFF vs 0x00 compare → all outputs 0 and ready=1 next cycle; no done pulse follows.
